gr_rotate_cell: RTL



---
 rtl/gr_rotate_cell.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gr_rotate_cell.sv
// Givens-rotation cell of the CORDIC QR array: applies the direction groups
// produced by the vectoring cell to one (x, y) pair, then gain-compensates.
module gr_rotate_cell #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC       = 10,
  parameter int D_WIDTH    = 4,
  parameter int ITER       = 12,
  parameter int K          = 621
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic signed [DATA_WIDTH-1:0] y_i,
  input  logic                         d_valid_i,
  input  logic        [D_WIDTH-1:0]    d_i,
  output logic                         busy_o,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] x_o,
  output logic signed [DATA_WIDTH-1:0] y_o
);

  localparam int DW     = DATA_WIDTH;
  localparam int GROUPS = ITER / D_WIDTH;
  localparam int SW     = $clog2(ITER + 1);
  localparam int CW     = $clog2(GROUPS + 1);

  localparam logic signed [DW-1:0]   SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [2*DW-1:0] K_W  = (2*DW)'(K);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROT   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        base_q, base_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d;
  logic signed [DW-1:0] xo_q, xo_d, yo_q, yo_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  // rotation chain temporaries
  logic signed [DW-1:0] rot_x, rot_y, xs, ys;
  logic signed [DW:0]   xw, yw;
  logic [SW-1:0]        sh;

  // scale temporaries
  logic signed [2*DW-1:0] px, py;

  // Clamp a one-bit-wider stage result back to DW bits.
  function automatic logic signed [DW-1:0] sat_n(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1]) return v[DW] ? SMIN : SMAX;
    return v[DW-1:0];
  endfunction

  // Clamp a double-width value to DW bits.
  function automatic logic signed [DW-1:0] sat_w(input logic signed [2*DW-1:0] v);
    logic [DW:0] upper;
    upper = v[2*DW-1:DW-1];
    if ((&upper) || !(|upper)) return v[DW-1:0];
    return v[2*DW-1] ? SMIN : SMAX;
  endfunction

  // Four chained, individually saturated micro-rotations for the current group.
  always_comb begin
    rot_x = x_q;
    rot_y = y_q;
    xs    = '0;
    ys    = '0;
    xw    = '0;
    yw    = '0;
    sh    = '0;
    for (int unsigned k = 0; k < D_WIDTH; k++) begin
      sh = base_q + SW'(k);
      xs = rot_x >>> sh;
      ys = rot_y >>> sh;
      if (d_i[k]) begin
        xw = {rot_x[DW-1], rot_x} + {ys[DW-1], ys};
        yw = {rot_y[DW-1], rot_y} - {xs[DW-1], xs};
      end else begin
        xw = {rot_x[DW-1], rot_x} - {ys[DW-1], ys};
        yw = {rot_y[DW-1], rot_y} + {xs[DW-1], xs};
      end
      rot_x = sat_n(xw);
      rot_y = sat_n(yw);
    end
  end

  // Gain compensation: full-width product, arithmetic shift, saturate.
  always_comb begin
    px = $signed({{DW{x_q[DW-1]}}, x_q}) * K_W;
    py = $signed({{DW{y_q[DW-1]}}, y_q}) * K_W;
  end

  // Next-state logic for the IDLE -> ROT -> SCALE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    x_d     = x_q;
    y_d     = y_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_i;
          y_d     = y_i;
          base_d  = '0;
          cnt_d   = '0;
          state_d = S_ROT;
        end
      end
      S_ROT: begin
        if (d_valid_i) begin
          x_d    = rot_x;
          y_d    = rot_y;
          base_d = base_q + SW'(D_WIDTH);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(GROUPS - 1)) state_d = S_SCALE;
        end
      end
      S_SCALE: begin
        xo_d    = sat_w(px >>> FRAC);
        yo_d    = sat_w(py >>> FRAC);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign x_o     = xo_q;
  assign y_o     = yo_q;

endmodule
